// File: rtl/clock_pkg.sv
// Shared BCD time-word constants, field slices and the two-digit BCD increment
// used by the clock counter and the downstream AM/PM, display and alarm logic.
package clock_pkg;

  localparam int unsigned TIME_W = 24;
  localparam int unsigned BCD2_W = 8;

  localparam logic [BCD2_W-1:0] HOUR_MIN       = 8'h01;
  localparam logic [BCD2_W-1:0] HOUR_MAX       = 8'h12;
  localparam logic [BCD2_W-1:0] HOUR_AMPM_EDGE = 8'h11;
  localparam logic [BCD2_W-1:0] MS_MIN         = 8'h00;
  localparam logic [BCD2_W-1:0] MS_MAX         = 8'h59;
  localparam logic [TIME_W-1:0] RESET_TIME     = 24'h120000;

  localparam int unsigned HR_HI = 23;
  localparam int unsigned HR_LO = 16;
  localparam int unsigned MN_HI = 15;
  localparam int unsigned MN_LO = 8;
  localparam int unsigned SC_HI = 7;
  localparam int unsigned SC_LO = 0;

  // Next value of a two-digit BCD field, wrapping max_v back to min_v.
  function automatic logic [BCD2_W-1:0] bcd2_next(input logic [BCD2_W-1:0] v,
                                                  input logic [BCD2_W-1:0] min_v,
                                                  input logic [BCD2_W-1:0] max_v);
    logic [BCD2_W-1:0] r;
    if (v == max_v)
      r = min_v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/bcd_clock_counter_if.sv
// Control and time-word bundle between the clock counter and its driver.
interface bcd_clock_counter_if;
  import clock_pkg::*;

  logic              set_ore;
  logic              set_min;
  logic              inc;
  logic              load;
  logic [TIME_W-1:0] load_data;
  logic [TIME_W-1:0] data_out;
  logic              tick_1s;

  modport master (output set_ore, set_min, inc, load, load_data,
                  input  data_out, tick_1s);

  modport slave  (input  set_ore, set_min, inc, load, load_data,
                  output data_out, tick_1s);
endinterface

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter in MIN_VAL..MAX_VAL with synchronous load and wrap carry.
module bcd2_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MIN_VAL   = 8'h00,
  parameter logic [7:0] MAX_VAL   = 8'h59,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       carry
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      value <= RESET_VAL;
    else if (load)
      value <= load_val;
    else if (en)
      value <= bcd2_next(value, MIN_VAL, MAX_VAL);
  end

  assign carry = en && (value == MAX_VAL);

endmodule

// File: rtl/bcd_clock_counter.sv
// 12-hour BCD hh:mm:ss time base: 1 s prescaler, ripple carry between fields,
// hour/minute setting through a shared increment button, and parallel load.
module bcd_clock_counter
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic                clock,
  input  logic                reset,
  bcd_clock_counter_if.slave  bus
);

  localparam int unsigned        PRESC_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc;
  logic               inc_q;
  logic               normal;
  logic               hr_set;
  logic               mn_set;
  logic               inc_edge;
  logic               tick;
  logic               sec_carry;
  logic               min_carry;
  logic               hr_carry_unused;
  logic               min_en;
  logic               hr_en;
  logic [7:0]         sec_val;
  logic [7:0]         min_val;
  logic [7:0]         hr_val;

  // Mode decode: load > set_ore > set_min > normal count.
  assign normal   = !bus.load && !bus.set_ore && !bus.set_min;
  assign hr_set   = !bus.load && bus.set_ore;
  assign mn_set   = !bus.load && !bus.set_ore && bus.set_min;
  assign inc_edge = bus.inc && !inc_q;
  assign tick     = normal && (presc == PRESC_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc <= '0;
      inc_q <= 1'b0;
    end else begin
      inc_q <= bus.inc;
      if (!normal || tick)
        presc <= '0;
      else
        presc <= presc + PRESC_W'(1);
    end
  end

  // Set modes step a single field and never propagate a carry.
  assign min_en = mn_set ? inc_edge : (normal && sec_carry);
  assign hr_en  = hr_set ? inc_edge : (normal && min_carry);

  bcd2_counter #(
    .MIN_VAL  (MS_MIN),
    .MAX_VAL  (MS_MAX),
    .RESET_VAL(RESET_TIME[SC_HI:SC_LO])
  ) u_sec (
    .clock   (clock),
    .reset   (reset),
    .en      (tick),
    .load    (bus.load),
    .load_val(bus.load_data[SC_HI:SC_LO]),
    .value   (sec_val),
    .carry   (sec_carry)
  );

  bcd2_counter #(
    .MIN_VAL  (MS_MIN),
    .MAX_VAL  (MS_MAX),
    .RESET_VAL(RESET_TIME[MN_HI:MN_LO])
  ) u_min (
    .clock   (clock),
    .reset   (reset),
    .en      (min_en),
    .load    (bus.load),
    .load_val(bus.load_data[MN_HI:MN_LO]),
    .value   (min_val),
    .carry   (min_carry)
  );

  bcd2_counter #(
    .MIN_VAL  (HOUR_MIN),
    .MAX_VAL  (HOUR_MAX),
    .RESET_VAL(RESET_TIME[HR_HI:HR_LO])
  ) u_hr (
    .clock   (clock),
    .reset   (reset),
    .en      (hr_en),
    .load    (bus.load),
    .load_val(bus.load_data[HR_HI:HR_LO]),
    .value   (hr_val),
    .carry   (hr_carry_unused)
  );

  assign bus.data_out = {hr_val, min_val, sec_val};
  assign bus.tick_1s  = tick;

endmodule

// File: doc/bcd_clock_counter.md
Name: bcd_clock_counter

Overview:
- Time base that produces the 24-bit packed BCD 12-hour time word consumed by the AM/PM generator, display mux and alarm logic.
- Divides the system clock to a 1 s tick and advances hh:mm:ss.
- Supports hour and minute setting through a shared increment button, plus a synchronous parallel load.
- Exports the one-cycle second tick so downstream logic can qualify time-word compares to a single cycle.

Parameters:
- TICK_DIV, 100_000_000, clock cycles per second tick; must be ≥ 2. The bench uses 4.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- set_ore  in  1  level; hour-setting mode.
- set_min  in  1  level; minute-setting mode.
- inc  in  1  level from debounced button; each rising edge is one increment.
- load  in  1  level; synchronous load of load_data.
- load_data  in  24  packed BCD: [23:16] hours, [15:8] minutes, [7:0] seconds.
- data_out  out  24  packed BCD time: [23:16] hours 01..12, [15:8] minutes 00..59, [7:0] seconds 00..59.
- tick_1s  out  1  one-cycle pulse, high in the cycle on whose closing edge the time advances.

Behaviour:
- Reset (asynchronous, immediate):
  - data_out = 24'h120000, prescaler = 0, tick_1s = 0, inc edge register = 0.
  - Reset mid-count or mid-set takes effect immediately and has priority over everything.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - tick_1s = (prescaler == TICK_DIV-1) and normal mode; prescaler then wraps to 0.
  - Normal mode means set_ore = 0, set_min = 0, load = 0.
  - In any set mode or during load, the prescaler is held at 0 and tick_1s = 0. Counting resumes from 0 the cycle after exit.
- Priority, per cycle: load > set_ore > set_min > normal count.
- load:
  - data_out = load_data at the next edge; the prescaler is cleared.
  - load_data must be valid BCD within range; other values are outside the contract and produce no defined result.
- inc edge detect:
  - inc_q registers inc every cycle, in all modes.
  - An edge is inc & ~inc_q.
  - Exactly one increment per edge; holding inc high gives no repeat.
  - Edges in normal mode are ignored.
- set_ore: each edge advances hours 01→02…→11→12→01. Minutes and seconds are unchanged.
- set_min:
  - Each edge advances minutes 00→…→59→00.
  - No carry into hours; seconds unchanged.
- Normal count on tick_1s:
  - Seconds +1 in BCD (units 9→0 with carry to tens; 59→00).
  - The seconds wrap carries into minutes, same rule.
  - The minutes wrap carries into hours: 11→12, 12→01, otherwise +1 BCD (09→10).
  - New value is visible on data_out the cycle after tick_1s.
  - 11:59:59 → 12:00:00 is the AM/PM boundary; this block does not track AM/PM.
- Latency and timing:
  - Every update of data_out is one clock edge after the qualifying condition.
  - data_out is driven only from registers, never combinationally from inputs.
- Invariants:
  - Every digit is in 0..9; seconds and minutes tens digit in 0..5; hours in {01..12}.
  - Never 00 hours, never 13.
- Simultaneous events:
  - set_ore and set_min both high: hours mode only.
  - load together with an inc edge: load wins and the edge is consumed.

Decomposition:
- Shared package clock_pkg holds:
  - BCD constants: HOUR_MIN = 8'h01, HOUR_MAX = 8'h12, HOUR_AMPM_EDGE = 8'h11, MS_MAX = 8'h59, RESET_TIME = 24'h120000.
  - Field slice indices for the packed time word.
  - The generate_AM_PM block reuses these.
- One sub-module, bcd2_counter: two-digit BCD counter with parameters MIN_VAL and MAX_VAL.
  - Inputs: en, load, load_val.
  - Outputs: value, carry (en and value == MAX_VAL).
  - Wraps MAX_VAL → MIN_VAL.
  - Instantiated three times: seconds 00–59, minutes 00–59, hours 01–12.
  - Set-mode increments drive en directly with the carry ignored.

Test Plan (TICK_DIV = 4):
- Release reset, idle 4 cycles → tick_1s high on the 4th cycle only; data_out 24'h120000 → 24'h120001 on the next cycle.
- Load 24'h115959, wait one tick → 24'h120000.
- Load 24'h125959, tick → 24'h010000.
- Load 24'h095959, tick → 24'h100000.
- set_ore = 1 from 24'h120000, three inc pulses each held 5 cycles → hours 01, 02, 03, one step per pulse, no repeat while held. Seconds stay 00 and tick_1s stays 0 throughout; after exit the first tick comes 4 cycles later.
- Load 24'h045930, then set_min = 1 and one inc edge → 24'h040030 (no hour carry). Assert set_ore and set_min together with one edge → 24'h050030.
- Counting mid-second at 24'h031207, assert reset asynchronously between clock edges → data_out = 24'h120000 before the next edge. Deassert → the count restarts with a full 4-cycle interval.
